// File: rtl/garage_door_ctrl_gen2.sv
// Second-generation garage door controller: edge-triggered commands,
// obstruction reversal with dead-time, travel watchdog, auto-close, latched fault.
module garage_door_ctrl_gen2 #(
    parameter int TRAVEL_MAX = 1000,
    parameter int AUTO_CLOSE = 500,
    parameter int DWELL      = 4,
    parameter int CNT_W      = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Active,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       Obstruct,
    input  logic       Fault_Clr,
    output logic       Up_Motor,
    output logic       Down_Motor,
    output logic       Fault,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UP    = 3'd1,
        S_DN    = 3'd2,
        S_DWELL = 3'd3,
        S_OPEN  = 3'd4,
        S_FAULT = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
    localparam logic [CNT_W-1:0] CLOSE_LAST  = CNT_W'(AUTO_CLOSE - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL - 1);

    state_e           state_q, state_d;
    logic             active_q;
    logic             rev_q, rev_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             restart;
    logic             act_re;
    logic             both;

    assign act_re = Active & ~active_q;
    assign both   = UP_Max & DN_Max;

    always_comb begin
        state_d = state_q;
        rev_d   = rev_q;
        restart = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (act_re) begin
                    if (DN_Max)      state_d = S_UP;
                    else if (UP_Max) state_d = S_DN;
                    else             state_d = S_UP;
                end
            end
            S_UP: begin
                if (UP_Max) begin
                    state_d = (AUTO_CLOSE == 0) ? S_IDLE : S_OPEN;
                end else if (timer_q == TRAVEL_LAST) begin
                    state_d = S_FAULT;
                end else if (act_re) begin
                    state_d = S_DWELL;
                    rev_d   = 1'b0;
                end
            end
            S_DN: begin
                if (DN_Max) begin
                    state_d = S_IDLE;
                end else if (Obstruct) begin
                    state_d = S_DWELL;
                    rev_d   = 1'b1;
                end else if (timer_q == TRAVEL_LAST) begin
                    state_d = S_FAULT;
                end else if (act_re) begin
                    state_d = S_DWELL;
                    rev_d   = 1'b0;
                end
            end
            S_DWELL: begin
                if (timer_q == DWELL_LAST) state_d = rev_q ? S_UP : S_IDLE;
            end
            S_OPEN: begin
                if (!UP_Max) begin
                    state_d = S_IDLE;
                end else if (act_re) begin
                    state_d = S_DN;
                end else if (AUTO_CLOSE != 0 && timer_q == CLOSE_LAST) begin
                    // a blocked beam holds the door open for another full period
                    if (Obstruct) restart = 1'b1;
                    else          state_d = S_DN;
                end
            end
            S_FAULT: begin
                if (Fault_Clr && !both) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (both && state_q != S_FAULT) state_d = S_FAULT;
    end

    always_comb begin
        if (state_d != state_q || restart) timer_d = '0;
        else if (timer_q == '1)            timer_d = timer_q;
        else                               timer_d = timer_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
            timer_q  <= '0;
            rev_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= Active;
            timer_q  <= timer_d;
            rev_q    <= rev_d;
        end
    end

    assign Up_Motor   = (state_q == S_UP);
    assign Down_Motor = (state_q == S_DN);
    assign Fault      = (state_q == S_FAULT);
    assign State      = state_q;

endmodule

// File: doc/garage_door_ctrl_gen2.md
# garage_door_ctrl_gen2

Parametrised second-generation garage door controller. It drives the up and down motor enables from a push-button and two end-of-travel switches. Over the basic IDLE/MV_UP/MV_DN controller it adds:
- rising-edge command detection and stop mid-travel
- obstruction auto-reversal with a motor dead-time
- travel watchdog
- auto-close timer
- latched fault state

It sits between the synchronised door sensors and the motor driver stage.

## Interface
- TRAVEL_MAX, 1000: max cycles a motor may run in one travel before FAULT (≥2).
- AUTO_CLOSE, 500: cycles the door stays fully open before closing; 0 disables auto-close.
- DWELL, 4: motor-off dead-time cycles before reversing or stopping (≥1).
- CNT_W, 16: width of the shared timer; must hold max(TRAVEL_MAX, AUTO_CLOSE, DWELL).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset. One clock; reset is asynchronous and active-low.
- Active  in  1  push-button; only its rising edge is a command. Synchronous to CLK.
- UP_Max  in  1  door fully open switch.
- DN_Max  in  1  door fully closed switch.
- Obstruct  in  1  beam-break sensor; 1 = obstacle.
- Fault_Clr  in  1  level; clears FAULT.
- Up_Motor  out  1  open motor enable.
- Down_Motor  out  1  close motor enable.
- Fault  out  1  1 while in FAULT.
- State  out  3  current state encoding.

## Operation
- States and encodings: IDLE=0, MV_UP=1, MV_DN=2, DWELL=3, OPEN_WAIT=4, FAULT=5. Codes 6 and 7 go to IDLE.
- `act_re = Active & ~Active_q`. Active_q is a register.
- Outputs are Moore, decoded from the state register:
  - Up_Motor = (State==MV_UP).
  - Down_Motor = (State==MV_DN).
  - Fault = (State==FAULT).
  - Never both motors at once.
- Timer: clears on every state change. Otherwise it increments each cycle and saturates.
- rev flag: register written on entry to DWELL. It selects the DWELL exit.
- Global rule: UP_Max&DN_Max in any non-FAULT state goes to FAULT. This overrides all other transitions.
- IDLE (act_re only):
  - DN_Max → MV_UP.
  - UP_Max → MV_DN.
  - Neither switch (door mid-way) → MV_UP.
- MV_UP, in priority order:
  1. UP_Max → OPEN_WAIT (IDLE if AUTO_CLOSE==0).
  2. Timer==TRAVEL_MAX-1 → FAULT.
  3. act_re → DWELL with rev=0.
  - Obstruct is ignored.
- MV_DN, in priority order:
  1. DN_Max → IDLE.
  2. Obstruct → DWELL with rev=1.
  3. Timer==TRAVEL_MAX-1 → FAULT.
  4. act_re → DWELL with rev=0.
- DWELL: motors off. At timer==DWELL-1, go to MV_UP if rev else IDLE.
- OPEN_WAIT:
  - !UP_Max → IDLE.
  - Else act_re → MV_DN.
  - Else at timer==AUTO_CLOSE-1: Obstruct restarts the timer in OPEN_WAIT; otherwise → MV_DN.
- FAULT: latched. Fault_Clr & !(UP_Max&DN_Max) → IDLE.
- Holding Active high produces exactly one command.

## Timing
- Reset (RST=0), asynchronous:
  - State=IDLE, Active_q=0, timer=0, rev=0.
  - Up_Motor=0, Down_Motor=0, Fault=0.
- Reset mid-travel drops both motors immediately, without waiting for the clock.
- Command latency: Active high at clock edge k (Active_q=0) → State and motor change after edge k. That is 1 cycle from the sampling edge.
- Run time at the watchdog: a motor runs exactly TRAVEL_MAX cycles, then FAULT appears on the next cycle.
- A switch asserted in the same cycle as the timeout wins over the timeout.
- Reversal: Obstruct sampled at edge k in MV_DN gives:
  - Down_Motor=0 from k.
  - DWELL cycles with both motors off.
  - Up_Motor=1 from edge k+DWELL.
- Auto-close: UP_Max reached at edge k → Down_Motor=1 from edge k+AUTO_CLOSE, if Obstruct is low at edge k+AUTO_CLOSE.
- Fault clear: 1 cycle latency; motors stay off.
- act_re arriving during DWELL or FAULT is discarded, not queued.

## Test plan
All scenarios use TRAVEL_MAX=20, AUTO_CLOSE=10, DWELL=3.
- Reset, DN_Max=1, pulse Active → Up_Motor=1 next cycle. Set UP_Max=1 after 5 cycles → State=4, both motors 0.
- From OPEN_WAIT with no input → Down_Motor=1 exactly 10 cycles after UP_Max was sampled. Repeat with Obstruct=1 at expiry → stays in State=4 and the timer restarts.
- In MV_DN, assert Obstruct → Down_Motor=0 next cycle, 3 cycles of both motors off, then Up_Motor=1.
- Hold Active high for 50 cycles from IDLE (DN_Max=1) → a single MV_UP. No UP_Max for 20 cycles → Fault=1, Up_Motor=0. Fault_Clr=1 → State=0.
- UP_Max=DN_Max=1 in any state (including with Active=1) → FAULT, motors 0. Fault_Clr is ignored while both switches stay high.
- Pull RST low while in MV_DN (between edges) → Down_Motor=0 immediately. Release → State=0, Fault=0.
